// File: rtl/vecmac_pkg.sv
// Shared types and helpers for the vector-MAC adder-tree sequencer.
package vecmac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MAX_LANES = 16;

    function automatic int stages_f(input int lanes);
        return (lanes < 4) ? 2 : $clog2(lanes);
    endfunction

    // A lane is kept unless it lies at or beyond rem on a partial final beat.
    function automatic logic keep_lane_f(input int lane, input int rem, input logic last);
        return (!last) || (rem == 0) || (lane < rem);
    endfunction

endpackage

// File: rtl/vecmac_seq_if.sv
// Command, product-beat, tree and result ports of the adder-tree sequencer.
interface vecmac_seq_if #(
    parameter int LANES = 4,
    parameter int INW   = 16,
    parameter int TREEW = 19,
    parameter int LENW  = 16,
    parameter int ACCW  = 32
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LENW-1:0]       cmd_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*INW-1:0]  in_prod_flat;
    logic                  tree_in_valid;
    logic [LANES*INW-1:0]  tree_prod_flat;
    logic                  tree_out_valid;
    logic [TREEW-1:0]      tree_sum;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACCW-1:0]       res_sum;
    logic                  res_ovf;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_len, in_valid, in_prod_flat, tree_out_valid, tree_sum, res_ready,
        input  cmd_ready, in_ready, tree_in_valid, tree_prod_flat, res_valid, res_sum, res_ovf, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_prod_flat, tree_out_valid, tree_sum, res_ready,
        output cmd_ready, in_ready, tree_in_valid, tree_prod_flat, res_valid, res_sum, res_ovf, busy
    );
endinterface

// File: rtl/vecmac_seq_lane_mask_gen.sv
// Keep mask for one product beat: zeroes tail lanes on a partial final beat.
module vecmac_seq_lane_mask_gen
    import vecmac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int REMW  = 2
) (
    input  logic [REMW-1:0]  rem,
    input  logic             last,
    output logic [LANES-1:0] keep
);

    // Per-lane keep decision
    always_comb begin
        keep = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            keep[i] = keep_lane_f(i, int'(rem), last);
        end
    end

endmodule

// File: rtl/vecmac_seq.sv
// Sequencer feeding LANES-wide product beats to the adder tree and
// accumulating the tree sums into one dot-product result.
module vecmac_seq
    import vecmac_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int INW    = 16,
    parameter int STAGES = stages_f(LANES),
    parameter int TREEW  = INW + STAGES + 1,
    parameter int LENW   = 16,
    parameter int ACCW   = 32
) (
    input  logic        clk,
    input  logic        rst,
    vecmac_seq_if.slave bus
);

    localparam int LOGL = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int REMW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;
    localparam logic [LENW-1:0] ONE_LEN  = LENW'(1);
    localparam logic [LENW-1:0] ZERO_LEN = {LENW{1'b0}};
    localparam logic [LENW-1:0] LANE_MSK = LENW'(LANES - 1);

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [LENW-1:0]      beats_r;
    logic [LENW-1:0]      iss_cnt_r;
    logic [LENW-1:0]      ret_cnt_r;
    logic [REMW-1:0]      rem_r;
    logic [ACCW-1:0]      acc_r;
    logic                 cmd_ready_r;
    logic                 in_ready_r;
    logic                 tree_in_valid_r;
    logic [LANES*INW-1:0] tree_prod_r;
    logic                 res_valid_r;
    logic [ACCW-1:0]      res_sum_r;
    logic                 res_ovf_r;
    logic                 busy_r;

    logic                 cmd_fire_s;
    logic                 in_fire_s;
    logic                 last_beat_s;
    logic                 tree_ret_s;
    logic                 drain_done_s;
    logic [REMW-1:0]      cmd_rem_s;
    logic [LENW-1:0]      cmd_beats_s;
    logic [LANES-1:0]     keep_s;
    logic [LANES*INW-1:0] masked_s;
    logic [TREEW-1:0]     tree_sum_s;
    logic [ACCW:0]        acc_sum_s;

    assign cmd_fire_s   = bus.cmd_valid & cmd_ready_r;
    assign in_fire_s    = bus.in_valid & in_ready_r;
    assign cmd_rem_s    = REMW'(bus.cmd_len & LANE_MSK);
    assign cmd_beats_s  = (bus.cmd_len >> LOGL) + {{(LENW-1){1'b0}}, (cmd_rem_s != {REMW{1'b0}})};
    assign last_beat_s  = (iss_cnt_r == (beats_r - ONE_LEN));
    assign tree_ret_s   = bus.tree_out_valid & ((state_r == ISSUE) | (state_r == DRAIN));
    assign drain_done_s = (ret_cnt_r == beats_r);
    assign tree_sum_s   = bus.tree_sum;
    // Carry out of the accumulator lands in the extra top bit.
    assign acc_sum_s    = {1'b0, acc_r} + (ACCW+1)'(tree_sum_s);

    vecmac_seq_lane_mask_gen #(
        .LANES (LANES),
        .REMW  (REMW)
    ) u_mask (
        .rem  (rem_r),
        .last (last_beat_s),
        .keep (keep_s)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign masked_s[g*INW +: INW] = keep_s[g] ? bus.in_prod_flat[g*INW +: INW] : {INW{1'b0}};
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) begin
                    state_nxt_s = (cmd_beats_s == ZERO_LEN) ? DONE : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (in_fire_s && last_beat_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                if (res_valid_r && bus.res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, handshake outputs and command bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_sum_r   <= {ACCW{1'b0}};
            beats_r     <= ZERO_LEN;
            rem_r       <= {REMW{1'b0}};
            iss_cnt_r   <= ZERO_LEN;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            in_ready_r  <= (state_nxt_s == ISSUE);
            busy_r      <= (state_nxt_s != IDLE);
            res_valid_r <= (state_nxt_s == DONE);
            if ((state_r != DONE) && (state_nxt_s == DONE)) begin
                res_sum_r <= (state_r == IDLE) ? {ACCW{1'b0}} : acc_r;
            end
            if (cmd_fire_s) begin
                beats_r   <= cmd_beats_s;
                rem_r     <= cmd_rem_s;
                iss_cnt_r <= ZERO_LEN;
            end else if (in_fire_s) begin
                iss_cnt_r <= iss_cnt_r + ONE_LEN;
            end
        end
    end

    // Accumulator and sticky wrap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r     <= {ACCW{1'b0}};
            res_ovf_r <= 1'b0;
            ret_cnt_r <= ZERO_LEN;
        end else if (cmd_fire_s) begin
            acc_r     <= {ACCW{1'b0}};
            res_ovf_r <= 1'b0;
            ret_cnt_r <= ZERO_LEN;
        end else if (tree_ret_s) begin
            acc_r     <= acc_sum_s[ACCW-1:0];
            res_ovf_r <= res_ovf_r | acc_sum_s[ACCW];
            ret_cnt_r <= ret_cnt_r + ONE_LEN;
        end
    end

    // Issue register in front of the tree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_in_valid_r <= 1'b0;
            tree_prod_r     <= {(LANES*INW){1'b0}};
        end else begin
            tree_in_valid_r <= in_fire_s;
            if (in_fire_s) begin
                tree_prod_r <= masked_s;
            end
        end
    end

    assign bus.cmd_ready      = cmd_ready_r;
    assign bus.in_ready       = in_ready_r;
    assign bus.tree_in_valid  = tree_in_valid_r;
    assign bus.tree_prod_flat = tree_prod_r;
    assign bus.res_valid      = res_valid_r;
    assign bus.res_sum        = res_sum_r;
    assign bus.res_ovf        = res_ovf_r;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_vecmac_seq.sv
// Bench for vecmac_seq with a pipelined adder tree model attached.
module tb_vecmac_seq;

    localparam int LANES  = 4;
    localparam int INW    = 16;
    localparam int STAGES = 2;
    localparam int TREEW  = 19;
    localparam int LENW   = 16;
    localparam int ACCW   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   tiv_cnt = 0;

    // Results captured by the command driver
    logic [ACCW-1:0] r_sum;
    logic            r_ovf;
    bit              r_timeout;
    int              r_lat;
    int              r_cmd_lat;
    bit              r_stable;
    bit              r_dropped;
    bit              r_busy_ready;
    int              r_tiv;
    logic [LANES*INW-1:0] beat_mem [0:255];

    vecmac_seq_if #(.LANES(LANES), .INW(INW), .TREEW(TREEW), .LENW(LENW), .ACCW(ACCW)) ifc ();

    vecmac_seq #(
        .LANES(LANES), .INW(INW), .STAGES(STAGES), .TREEW(TREEW), .LENW(LENW), .ACCW(ACCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ifc.tree_in_valid) tiv_cnt <= tiv_cnt + 1;

    // Adder tree model: sum of lanes, STAGES clocks deep, no backpressure
    function automatic logic [TREEW-1:0] lane_sum(input logic [LANES*INW-1:0] v);
        logic [TREEW-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) s = s + TREEW'(v[i*INW +: INW]);
        return s;
    endfunction

    logic [TREEW-1:0] tp_sum [STAGES];
    logic             tp_v   [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                tp_v[i]   <= 1'b0;
                tp_sum[i] <= '0;
            end
        end else begin
            tp_v[0]   <= ifc.tree_in_valid;
            tp_sum[0] <= lane_sum(ifc.tree_prod_flat);
            for (int i = 1; i < STAGES; i++) begin
                tp_v[i]   <= tp_v[i-1];
                tp_sum[i] <= tp_sum[i-1];
            end
        end
    end

    assign ifc.tree_out_valid = tp_v[STAGES-1];
    assign ifc.tree_sum       = tp_sum[STAGES-1];

    // Reference: plain sum of the first len elements, element k = lane k%LANES of beat k/LANES
    function automatic longint unsigned model_total(input int len);
        longint unsigned t;
        logic [LANES*INW-1:0] bv;
        t = 0;
        for (int k = 0; k < len; k++) begin
            bv = beat_mem[k / LANES];
            t  = t + longint'(bv[(k % LANES)*INW +: INW]);
        end
        return t;
    endfunction

    // Drives one command end to end; gap_mode 0=continuous, 1=alternate, 2=random
    task automatic do_cmd(input int len, input bit rnd_data, input logic [INW-1:0] fill,
                          input int gap_mode, input int rr_delay, input bit probe_busy);
        int n;
        int beats;
        int b;
        int guard;
        int cmd_cyc;
        int last_cyc;
        int tiv0;
        bit v;
        bit fire;
        logic [LANES*INW-1:0] data;
        r_timeout = 1'b0; r_stable = 1'b1; r_dropped = 1'b0; r_busy_ready = 1'b0;
        tiv0 = tiv_cnt;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_len   = LENW'(len);
        n = 0;
        while (!ifc.cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!ifc.cmd_ready) r_timeout = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        cmd_cyc  = cyc;
        last_cyc = cyc;
        beats = (len + LANES - 1) / LANES;
        b = 0; guard = 0;
        while (b < beats && guard < 2000) begin
            case (gap_mode)
                1:       v = (guard % 2 == 0);
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            for (int l = 0; l < LANES; l++) data[l*INW +: INW] = rnd_data ? INW'($urandom) : fill;
            ifc.in_valid     = v;
            ifc.in_prod_flat = data;
            if (probe_busy) begin
                ifc.cmd_valid = 1'b1;
                ifc.cmd_len   = LENW'(3);
                if (ifc.cmd_ready || !ifc.busy) r_busy_ready = 1'b1;
            end
            fire = v && ifc.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                beat_mem[b] = data;
                b++;
                last_cyc = cyc;
            end
            guard++;
        end
        if (b < beats) r_timeout = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.cmd_valid = 1'b0;
        n = 0;
        while (!ifc.res_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!ifc.res_valid) r_timeout = 1'b1;
        r_lat     = cyc - last_cyc;
        r_cmd_lat = cyc - cmd_cyc;
        r_sum     = ifc.res_sum;
        r_ovf     = ifc.res_ovf;
        for (int i = 0; i < rr_delay; i++) begin
            @(posedge clk); #1;
            if (!ifc.res_valid || ifc.res_sum !== r_sum || ifc.res_ovf !== r_ovf) r_stable = 1'b0;
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        r_dropped = !ifc.res_valid;
        r_tiv = tiv_cnt - tiv0;
    endtask

    task automatic test_reset();
        logic [LANES*INW+ACCW+6:0] outs;
        outs = {ifc.cmd_ready, ifc.in_ready, ifc.tree_in_valid, ifc.tree_prod_flat,
                ifc.res_valid, ifc.res_sum, ifc.res_ovf, ifc.busy};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ifc.cmd_ready !== 1'b1 || ifc.busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: cmd_ready=%b busy=%b want 1/0", ifc.cmd_ready, ifc.busy);
        end
    endtask

    task automatic test_basic();
        do_cmd(8, 1'b0, 16'h0001, 0, 0, 1'b0);
        checks++;
        if (r_timeout || r_sum !== 20'd8 || r_ovf !== 1'b0) begin
            errors++; $display("FAIL basic_sum: got %0d ovf=%b to=%b want 8 ovf=0", r_sum, r_ovf, r_timeout);
        end
        checks++;
        if (r_lat !== 4) begin
            errors++; $display("FAIL basic_latency: got %0d want 4", r_lat);
        end
        checks++;
        if (r_tiv !== 2 || !r_dropped) begin
            errors++; $display("FAIL basic_pulses: tree_in_valid=%0d dropped=%b want 2/1", r_tiv, r_dropped);
        end
    endtask

    task automatic test_tail_mask();
        do_cmd(6, 1'b0, 16'hFFFF, 0, 0, 1'b0);
        checks++;
        if (r_timeout || r_sum !== 20'd393210 || r_ovf !== 1'b0) begin
            errors++; $display("FAIL tail_mask: got %0d ovf=%b want 393210 ovf=0", r_sum, r_ovf);
        end
        do_cmd(3, 1'b1, 16'h0000, 0, 0, 1'b0);
        checks++;
        if (r_timeout || r_sum !== ACCW'(model_total(3))) begin
            errors++; $display("FAIL tail_single_beat: got %0d want %0d", r_sum, ACCW'(model_total(3)));
        end
    endtask

    task automatic test_zero_len();
        do_cmd(0, 1'b0, 16'h1234, 0, 0, 1'b0);
        checks++;
        if (r_timeout || r_sum !== 20'd0 || r_ovf !== 1'b0 || r_cmd_lat !== 0) begin
            errors++; $display("FAIL zero_len: got sum=%0d ovf=%b lat=%0d want 0/0/0", r_sum, r_ovf, r_cmd_lat);
        end
        checks++;
        if (r_tiv !== 0) begin
            errors++; $display("FAIL zero_len_pulses: got %0d want 0", r_tiv);
        end
    endtask

    task automatic test_gaps_hold();
        longint unsigned t;
        do_cmd(16, 1'b1, 16'h0000, 1, 5, 1'b1);
        t = model_total(16);
        checks++;
        if (r_timeout || r_sum !== ACCW'(t) || r_ovf !== (t >= (64'd1 << ACCW))) begin
            errors++; $display("FAIL gaps_sum: got %0d ovf=%b want %0d", r_sum, r_ovf, ACCW'(t));
        end
        checks++;
        if (!r_stable || !r_dropped) begin
            errors++; $display("FAIL gaps_hold: stable=%b dropped=%b want 1/1", r_stable, r_dropped);
        end
        checks++;
        if (r_busy_ready) begin
            errors++; $display("FAIL busy_cmd_ready: got cmd_ready seen while busy, want 0");
        end
        checks++;
        if (r_lat !== 4 || r_tiv !== 4) begin
            errors++; $display("FAIL gaps_timing: lat=%0d pulses=%0d want 4/4", r_lat, r_tiv);
        end
    endtask

    task automatic test_overflow();
        do_cmd(64, 1'b0, 16'hFFFF, 0, 0, 1'b0);
        checks++;
        if (r_timeout || r_sum !== 20'd1048512 || r_ovf !== 1'b1) begin
            errors++; $display("FAIL overflow: got %0d ovf=%b want 1048512 ovf=1", r_sum, r_ovf);
        end
    endtask

    task automatic test_random();
        int len;
        longint unsigned t;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(0, 40);
            do_cmd(len, 1'b1, 16'h0000, 2, $urandom_range(0, 3), 1'b0);
            t = model_total(len);
            checks++;
            if (r_timeout || r_sum !== ACCW'(t) || r_ovf !== (t >= (64'd1 << ACCW))) begin
                errors++;
                $display("FAIL random_%0d len=%0d: got %0d ovf=%b want %0d ovf=%b", it, len, r_sum, r_ovf,
                         ACCW'(t), (t >= (64'd1 << ACCW)));
            end
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        logic [LANES*INW+ACCW+6:0] outs;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_len   = LENW'(8);
        @(posedge clk); #1;
        ifc.cmd_valid    = 1'b0;
        ifc.in_valid     = 1'b1;
        ifc.in_prod_flat = {LANES{16'h0005}};
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.busy !== 1'b1 || ifc.in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_drain: busy=%b in_ready=%b want 1/0", ifc.busy, ifc.in_ready);
        end
        rst = 1'b1;
        #1;
        outs = {ifc.cmd_ready, ifc.in_ready, ifc.tree_in_valid, ifc.tree_prod_flat,
                ifc.res_valid, ifc.res_sum, ifc.res_ovf, ifc.busy};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL abort_outputs: got %h want 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ifc.res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_result: res_valid seen after abort, want none");
        end
        do_cmd(4, 1'b0, 16'h0002, 0, 0, 1'b0);
        checks++;
        if (r_timeout || r_sum !== 20'd8 || r_ovf !== 1'b0) begin
            errors++; $display("FAIL after_abort: got %0d ovf=%b want 8 ovf=0", r_sum, r_ovf);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.cmd_valid    = 1'b0;
        ifc.cmd_len      = '0;
        ifc.in_valid     = 1'b0;
        ifc.in_prod_flat = '0;
        ifc.res_ready    = 1'b0;
        #12;
        test_reset();
        test_basic();
        test_tail_mask();
        test_zero_len();
        test_gaps_hold();
        test_overflow();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
